// File: rtl/axis_sha3_stream_arbiter_if.sv
// AXI-Stream bundle around the SHA3 input arbiter.
//  s_* : N_SRC requester lanes, packed side by side (lane i at [i*W +: W])
//  m_* : single stream toward the SHA3 receiver/core
// Modports:
//  slave  : arbiter view (consumes s_*, m_tready; produces s_tready, m_*)
//  master : environment view (requesters plus downstream sink)
interface axis_sha3_stream_arbiter_if #(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 2
);
  logic [N_SRC*DATA_WIDTH-1:0] s_tdata;
  logic [N_SRC-1:0]            s_tvalid;
  logic [N_SRC-1:0]            s_tlast;
  logic [N_SRC-1:0]            s_tid;
  logic [N_SRC*USER_WIDTH-1:0] s_tuser;
  logic [N_SRC*DEST_WIDTH-1:0] s_tdest;
  logic [N_SRC-1:0]            s_tready;

  logic [DATA_WIDTH-1:0]       m_tdata;
  logic                        m_tvalid;
  logic                        m_tlast;
  logic                        m_tid;
  logic [USER_WIDTH-1:0]       m_tuser;
  logic [DEST_WIDTH-1:0]       m_tdest;
  logic                        m_tready;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, s_tid, s_tuser, s_tdest, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, m_tid, m_tuser, m_tdest
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, s_tid, s_tuser, s_tdest, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid, m_tuser, m_tdest
  );
endinterface

// File: rtl/axis_sha3_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing the SHA3 core's single
// AXI-Stream input among N_SRC requesters. A granted source owns the
// master port until its TLAST beat handshakes. TUSER (SHA type) and TDEST
// are latched at grant time and held for the whole packet.
// Ports:
//  ACLK       clock
//  ARESETn    synchronous active-low reset
//  axis       stream bundle (slave modport): s_* requester lanes, m_* output
//  grant      one-hot current owner, 0 when idle
//  busy       1 while a packet is in progress
//  pkt_beats  beats accepted in the current/last packet (saturating)
module axis_sha3_stream_arbiter #(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  axis_sha3_stream_arbiter_if.slave     axis,
  output logic [N_SRC-1:0]              grant,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          pkt_beats
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;       // last served port; scan starts at ptr+1
  logic [PTR_W-1:0] gidx;      // binary index of the granted port
  logic [PTR_W-1:0] win_idx;
  logic             win_found;
  logic             hs;
  logic             g_last;

  // Round-robin pick: first valid requester after ptr, wrapping modulo N_SRC.
  always_comb begin
    logic [PTR_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      cand = PTR_W'((32'(ptr) + k) % 32'(N_SRC));
      if (!win_found && axis.s_tvalid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Zero-latency pass-through of the granted lane; nothing moves while idle.
  always_comb begin
    axis.s_tready = '0;
    axis.m_tdata  = '0;
    axis.m_tvalid = 1'b0;
    axis.m_tlast  = 1'b0;
    axis.m_tid    = 1'b0;
    if (state == BUSY) begin
      axis.m_tdata        = axis.s_tdata[gidx*DATA_WIDTH +: DATA_WIDTH];
      axis.m_tvalid       = axis.s_tvalid[gidx];
      axis.m_tlast        = axis.s_tlast[gidx];
      axis.m_tid          = axis.s_tid[gidx];
      axis.s_tready[gidx] = axis.m_tready;
    end
  end

  assign g_last = axis.s_tlast[gidx];
  assign hs     = (state == BUSY) && axis.s_tvalid[gidx] && axis.m_tready;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state        <= IDLE;
      grant        <= '0;
      busy         <= 1'b0;
      pkt_beats    <= '0;
      ptr          <= PTR_W'(N_SRC - 1);
      gidx         <= '0;
      axis.m_tuser <= '0;
      axis.m_tdest <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant        <= {{(N_SRC-1){1'b0}}, 1'b1} << win_idx;
            gidx         <= win_idx;
            axis.m_tuser <= axis.s_tuser[win_idx*USER_WIDTH +: USER_WIDTH];
            axis.m_tdest <= axis.s_tdest[win_idx*DEST_WIDTH +: DEST_WIDTH];
            pkt_beats    <= '0;
            busy         <= 1'b1;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (hs) begin
            if (pkt_beats != '1) begin
              pkt_beats <= pkt_beats + 1'b1;
            end
            if (g_last) begin
              ptr   <= gidx;
              grant <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_sha3_stream_arbiter.sv
// Bench for axis_sha3_stream_arbiter: per-port beat queues feed the
// requester lanes, expected master beats go into a scoreboard queue in the
// hand-derived arbitration order, and a monitor pops/compares on every
// master handshake. Cycle-exact grant/busy/pkt_beats checks run in the
// main sequence. The beat counter is narrowed to 2 bits so a 4-beat
// packet reaches saturation.
module tb_axis_sha3_stream_arbiter;
  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int DSW = 8;
  localparam int UW  = 2;
  localparam int CW  = 2;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  axis_sha3_stream_arbiter_if #(.N_SRC(N), .DATA_WIDTH(DW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) bus ();

  logic [N-1:0]  grant;
  logic          busy;
  logic [CW-1:0] pkt_beats;

  axis_sha3_stream_arbiter #(
    .N_SRC(N), .DATA_WIDTH(DW), .DEST_WIDTH(DSW), .USER_WIDTH(UW), .CNT_WIDTH(CW)
  ) dut (
    .ACLK(ACLK),
    .ARESETn(ARESETn),
    .axis(bus.slave),
    .grant(grant),
    .busy(busy),
    .pkt_beats(pkt_beats)
  );

  typedef struct {
    logic [DW-1:0]  data;
    logic           last;
    logic [UW-1:0]  user;
    logic [DSW-1:0] dest;
  } beat_t;

  typedef struct {
    logic [DW-1:0]  data;
    logic           last;
    logic           tid;
    logic [UW-1:0]  user;
    logic [DSW-1:0] dest;
    int             src;
  } exp_t;

  beat_t pbeat [N][32];
  int    wr [N];
  int    rd [N];
  exp_t  sbq [$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // tid of each beat is the data LSB, so it is checked as a pass-through bit.
  task automatic load(input int p, input logic [DW-1:0] d, input logic l,
                      input logic [UW-1:0] u, input logic [DSW-1:0] dst);
    pbeat[p][wr[p]] = '{data: d, last: l, user: u, dest: dst};
    wr[p]++;
  endtask

  task automatic expect_beat(input int p, input logic [DW-1:0] d, input logic l,
                             input logic [UW-1:0] u, input logic [DSW-1:0] dst);
    exp_t e;
    e = '{data: d, last: l, tid: d[0], user: u, dest: dst, src: p};
    sbq.push_back(e);
  endtask

  task automatic flush_sources();
    for (int i = 0; i < N; i++) rd[i] = wr[i];
  endtask

  // Requester model: present queue heads, advance a lane after its handshake.
  initial begin : driver
    logic [N-1:0] hs;
    for (int i = 0; i < N; i++) begin
      wr[i] = 0;
      rd[i] = 0;
    end
    bus.s_tvalid = '0;
    bus.s_tdata  = '0;
    bus.s_tlast  = '0;
    bus.s_tid    = '0;
    bus.s_tuser  = '0;
    bus.s_tdest  = '0;
    forever begin
      @(negedge ACLK);
      hs = bus.s_tvalid & bus.s_tready;
      @(posedge ACLK);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && rd[i] != wr[i]) rd[i]++;
        if (rd[i] != wr[i]) begin
          bus.s_tvalid[i]            = 1'b1;
          bus.s_tdata[i*DW +: DW]    = pbeat[i][rd[i]].data;
          bus.s_tlast[i]             = pbeat[i][rd[i]].last;
          bus.s_tid[i]               = pbeat[i][rd[i]].data[0];
          bus.s_tuser[i*UW +: UW]    = pbeat[i][rd[i]].user;
          bus.s_tdest[i*DSW +: DSW]  = pbeat[i][rd[i]].dest;
        end else begin
          bus.s_tvalid[i]            = 1'b0;
          bus.s_tdata[i*DW +: DW]    = '0;
          bus.s_tlast[i]             = 1'b0;
          bus.s_tid[i]               = 1'b0;
          bus.s_tuser[i*UW +: UW]    = '0;
          bus.s_tdest[i*DSW +: DSW]  = '0;
        end
      end
    end
  end

  // Monitor: every master handshake must match the scoreboard head.
  always @(negedge ACLK) begin
    if (bus.m_tvalid && bus.m_tready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL mon_unexpected: got beat 0x%0h expected none (t=%0t)", bus.m_tdata, $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("mon_data",  32'(bus.m_tdata), 32'(e.data));
        check("mon_last",  32'(bus.m_tlast), 32'(e.last));
        check("mon_tid",   32'(bus.m_tid),   32'(e.tid));
        check("mon_tuser", 32'(bus.m_tuser), 32'(e.user));
        check("mon_tdest", 32'(bus.m_tdest), 32'(e.dest));
        check("mon_grant", 32'(grant),       32'(1) << e.src);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [3:0] g2 [16];
    logic       pat [8];
    g2  = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4,
            4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h0};
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bus.m_tready = 1'b1;
    ARESETn = 1'b0;

    // Reset state
    @(negedge ACLK);
    check("rst_grant",    32'(grant),        32'h0);
    check("rst_busy",     32'(busy),         32'h0);
    check("rst_pkt",      32'(pkt_beats),    32'h0);
    check("rst_mvalid",   32'(bus.m_tvalid), 32'h0);
    check("rst_sready",   32'(bus.s_tready), 32'h0);
    @(posedge ACLK); #1 ARESETn = 1'b1;
    @(negedge ACLK);

    // 1: lone 3-beat packet on port 2
    load(2, 16'h0001, 1'b0, 2'b01, 8'h22);
    load(2, 16'h0002, 1'b0, 2'b01, 8'h22);
    load(2, 16'h0003, 1'b1, 2'b01, 8'h22);
    expect_beat(2, 16'h0001, 1'b0, 2'b01, 8'h22);
    expect_beat(2, 16'h0002, 1'b0, 2'b01, 8'h22);
    expect_beat(2, 16'h0003, 1'b1, 2'b01, 8'h22);
    @(negedge ACLK);
    check("t1_idle_grant", 32'(grant), 32'h0);
    check("t1_idle_busy",  32'(busy),  32'h0);
    @(negedge ACLK);
    check("t1_grant",  32'(grant),        32'h4);
    check("t1_busy",   32'(busy),         32'h1);
    check("t1_sready", 32'(bus.s_tready), 32'h4);
    check("t1_pkt0",   32'(pkt_beats),    32'h0);
    @(negedge ACLK);
    check("t1_pkt1", 32'(pkt_beats), 32'h1);
    @(negedge ACLK);
    check("t1_pkt2", 32'(pkt_beats), 32'h2);
    @(negedge ACLK);
    check("t1_end_busy",  32'(busy),      32'h0);
    check("t1_end_grant", 32'(grant),     32'h0);
    check("t1_end_pkt",   32'(pkt_beats), 32'h3);

    // 2: all ports request 2-beat packets; port 0 has a second one
    @(posedge ACLK); #1 ARESETn = 1'b0;
    @(posedge ACLK); #1 ARESETn = 1'b1;
    @(negedge ACLK);
    for (int i = 0; i < N; i++) begin
      for (int b = 0; b < 2; b++) begin
        load(i, 16'h1000 + 16'(i*256 + b), b == 1, UW'(i), 8'(8'h30 + i));
      end
    end
    load(0, 16'h1800, 1'b0, 2'b11, 8'h3F);
    load(0, 16'h1801, 1'b1, 2'b11, 8'h3F);
    for (int i = 0; i < N; i++) begin
      for (int b = 0; b < 2; b++) begin
        expect_beat(i, 16'h1000 + 16'(i*256 + b), b == 1, UW'(i), 8'(8'h30 + i));
      end
    end
    expect_beat(0, 16'h1800, 1'b0, 2'b11, 8'h3F);
    expect_beat(0, 16'h1801, 1'b1, 2'b11, 8'h3F);
    for (int k = 0; k < 16; k++) begin
      @(negedge ACLK);
      check($sformatf("t2_grant_c%0d", k), 32'(grant), 32'(g2[k]));
    end

    // 3: port 1 under toggling m_tready, port 3 waiting; counter saturates
    load(1, 16'h2100, 1'b0, 2'b10, 8'h41);
    load(1, 16'h2101, 1'b0, 2'b10, 8'h41);
    load(1, 16'h2102, 1'b0, 2'b10, 8'h41);
    load(1, 16'h2103, 1'b1, 2'b10, 8'h41);
    load(3, 16'h2300, 1'b0, 2'b01, 8'h43);
    load(3, 16'h2301, 1'b1, 2'b01, 8'h43);
    expect_beat(1, 16'h2100, 1'b0, 2'b10, 8'h41);
    expect_beat(1, 16'h2101, 1'b0, 2'b10, 8'h41);
    expect_beat(1, 16'h2102, 1'b0, 2'b10, 8'h41);
    expect_beat(1, 16'h2103, 1'b1, 2'b10, 8'h41);
    expect_beat(3, 16'h2300, 1'b0, 2'b01, 8'h43);
    expect_beat(3, 16'h2301, 1'b1, 2'b01, 8'h43);
    @(negedge ACLK);
    for (int k = 0; k < 8; k++) begin
      @(posedge ACLK); #1 bus.m_tready = pat[k];
      @(negedge ACLK);
      check($sformatf("t3_sready_c%0d", k), 32'(bus.s_tready),
            (k <= 6 && pat[k]) ? 32'h2 : 32'h0);
    end
    check("t3_pkt_sat", 32'(pkt_beats), 32'h3);
    @(posedge ACLK); #1 bus.m_tready = 1'b1;
    repeat (4) @(negedge ACLK);

    // 4: TUSER/TDEST change on beat 1 must be ignored
    load(0, 16'h4000, 1'b0, 2'b10, 8'h50);
    load(0, 16'h4001, 1'b1, 2'b01, 8'h5A);
    expect_beat(0, 16'h4000, 1'b0, 2'b10, 8'h50);
    expect_beat(0, 16'h4001, 1'b1, 2'b10, 8'h50);
    repeat (4) @(negedge ACLK);

    // 5: reset mid-packet on port 3, then ports 0 and 3 compete
    for (int b = 0; b < 4; b++) load(3, 16'h5300 + 16'(b), b == 3, 2'b11, 8'h63);
    expect_beat(3, 16'h5300, 1'b0, 2'b11, 8'h63);
    expect_beat(3, 16'h5301, 1'b0, 2'b11, 8'h63);
    @(negedge ACLK);
    @(negedge ACLK);
    check("t5_grant3", 32'(grant), 32'h8);
    @(posedge ACLK); #1 ARESETn = 1'b0;
    @(negedge ACLK);
    flush_sources();
    check("t5_pkt_pre", 32'(pkt_beats), 32'h1);
    @(posedge ACLK); #1 ARESETn = 1'b1;
    @(negedge ACLK);
    check("t5_rst_grant",  32'(grant),        32'h0);
    check("t5_rst_busy",   32'(busy),         32'h0);
    check("t5_rst_pkt",    32'(pkt_beats),    32'h0);
    check("t5_rst_mvalid", 32'(bus.m_tvalid), 32'h0);
    load(0, 16'h5001, 1'b1, 2'b01, 8'h70);
    load(3, 16'h5303, 1'b1, 2'b10, 8'h73);
    expect_beat(0, 16'h5001, 1'b1, 2'b01, 8'h70);
    expect_beat(3, 16'h5303, 1'b1, 2'b10, 8'h73);
    @(negedge ACLK);
    check("t5_idle_grant", 32'(grant), 32'h0);
    @(negedge ACLK);
    check("t5_grant0", 32'(grant), 32'h1);
    repeat (3) @(negedge ACLK);

    // 6: single-beat packets from ports 1 and 2
    load(1, 16'h6101, 1'b1, 2'b00, 8'h81);
    load(2, 16'h6202, 1'b1, 2'b11, 8'h82);
    expect_beat(1, 16'h6101, 1'b1, 2'b00, 8'h81);
    expect_beat(2, 16'h6202, 1'b1, 2'b11, 8'h82);
    @(negedge ACLK);
    check("t6_c0_grant", 32'(grant), 32'h0);
    @(negedge ACLK);
    check("t6_c1_grant", 32'(grant), 32'h2);
    check("t6_c1_busy",  32'(busy),  32'h1);
    @(negedge ACLK);
    check("t6_c2_busy",  32'(busy),      32'h0);
    check("t6_c2_pkt",   32'(pkt_beats), 32'h1);
    @(negedge ACLK);
    check("t6_c3_grant", 32'(grant), 32'h4);
    @(negedge ACLK);
    check("t6_c4_busy",  32'(busy),      32'h0);
    check("t6_c4_pkt",   32'(pkt_beats), 32'h1);

    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(negedge ACLK);
    check("scoreboard_drained", 32'(sbq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
